// File: rtl/tpram_wr_arb.sv
// Write-port controller for the 512x64 math-unit TPRAM: round-robin share of the
// single write port between eFPGA fabric writes and the math-block result stream.
module tpram_wr_arb (
  input  logic        EFPGA_TPRAM_W_CLK,
  input  logic        EFPGA_TPRAM_W_RSTN,
  input  logic        FAB_REQ,
  input  logic [11:0] FAB_ADDR,
  input  logic [1:0]  FAB_MODE,
  input  logic [31:0] FAB_DATA,
  output logic        FAB_GNT,
  input  logic        MATHB_VALID,
  input  logic [31:0] MATHB_DATA,
  output logic        MATHB_RDY,
  input  logic [11:0] CFG_MB_BASE,
  input  logic [9:0]  CFG_MB_LEN,
  input  logic        CFG_MB_CIRC,
  input  logic        CFG_MB_START,
  input  logic        CFG_MB_STOP,
  input  logic        TPRAM_POWERDN,
  output logic        MB_BUSY,
  output logic        MB_DONE,
  output logic        MB_WRAP,
  output logic [10:0] MB_WCNT,
  output logic        EFPGA_TPRAM_WE,
  output logic        EFPGA_TPRAM_WDSEL,
  output logic [1:0]  EFPGA_TPRAM_W_MODE,
  output logic [11:0] EFPGA_TPRAM_W_ADDR,
  output logic [31:0] EFPGA_TPRAM_W_DATA,
  output logic [31:0] MATHB_TPRAM_W_DATA
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [9:0]  base_q, base_d;
  logic [9:0]  len_q, len_d;
  logic        circ_q, circ_d;
  logic [9:0]  offset_q, offset_d;
  logic [10:0] wcnt_q, wcnt_d;
  logic        last_mb_q, last_mb_d;
  logic        done_q, done_d;
  logic        wrap_q, wrap_d;
  logic        we_q, we_d;
  logic        wdsel_q, wdsel_d;
  logic [1:0]  w_mode_q, w_mode_d;
  logic [11:0] w_addr_q, w_addr_d;
  logic [31:0] w_data_q, w_data_d;
  logic [31:0] mb_data_q, mb_data_d;

  logic        fab_req, mb_req, fab_gnt, mb_gnt;
  logic [9:0]  word_idx;

  // Grants are also held off while reset is asserted so every output reads 0.
  assign fab_req  = FAB_REQ & ~TPRAM_POWERDN & EFPGA_TPRAM_W_RSTN;
  assign mb_req   = (state_q == RUN) & MATHB_VALID & ~TPRAM_POWERDN & EFPGA_TPRAM_W_RSTN;
  assign fab_gnt  = fab_req & (~mb_req | last_mb_q);
  assign mb_gnt   = mb_req & (~fab_req | ~last_mb_q);
  assign word_idx = base_q + offset_q;

  assign FAB_GNT            = fab_gnt;
  assign MATHB_RDY          = mb_gnt;
  assign MB_BUSY            = (state_q == RUN);
  assign MB_DONE            = done_q;
  assign MB_WRAP            = wrap_q;
  assign MB_WCNT            = wcnt_q;
  assign EFPGA_TPRAM_WE     = we_q;
  assign EFPGA_TPRAM_WDSEL  = wdsel_q;
  assign EFPGA_TPRAM_W_MODE = w_mode_q;
  assign EFPGA_TPRAM_W_ADDR = w_addr_q;
  assign EFPGA_TPRAM_W_DATA = w_data_q;
  assign MATHB_TPRAM_W_DATA = mb_data_q;

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    len_d     = len_q;
    circ_d    = circ_q;
    offset_d  = offset_q;
    wcnt_d    = wcnt_q;
    done_d    = 1'b0;
    wrap_d    = 1'b0;
    last_mb_d = last_mb_q;

    if (mb_gnt) begin
      last_mb_d = 1'b1;
      if (wcnt_q != 11'd1024) wcnt_d = wcnt_q + 11'd1;
      if (offset_q == len_q) begin
        offset_d = 10'd0;
        if (circ_q) begin
          wrap_d = 1'b1;
        end else begin
          done_d  = ~CFG_MB_STOP;
          state_d = IDLE;
        end
      end else begin
        offset_d = offset_q + 10'd1;
      end
    end else if (fab_gnt) begin
      last_mb_d = 1'b0;
    end

    // STOP overrides both START and end-of-window; the word granted this cycle still lands.
    if (CFG_MB_STOP) begin
      state_d = IDLE;
    end else if (state_q == IDLE && CFG_MB_START) begin
      state_d  = RUN;
      base_d   = CFG_MB_BASE[11:2];
      len_d    = CFG_MB_LEN;
      circ_d   = CFG_MB_CIRC;
      offset_d = 10'd0;
      wcnt_d   = 11'd0;
    end
  end

  always_comb begin
    we_d      = fab_gnt | mb_gnt;
    wdsel_d   = wdsel_q;
    w_mode_d  = w_mode_q;
    w_addr_d  = w_addr_q;
    w_data_d  = w_data_q;
    mb_data_d = mb_data_q;
    if (mb_gnt) begin
      wdsel_d   = 1'b1;
      w_mode_d  = 2'b00;
      w_addr_d  = {word_idx, 2'b00};
      mb_data_d = MATHB_DATA;
    end else if (fab_gnt) begin
      wdsel_d  = 1'b0;
      w_mode_d = FAB_MODE;
      w_addr_d = FAB_ADDR;
      w_data_d = FAB_DATA;
    end
  end

  always_ff @(posedge EFPGA_TPRAM_W_CLK or negedge EFPGA_TPRAM_W_RSTN) begin
    if (!EFPGA_TPRAM_W_RSTN) begin
      state_q   <= IDLE;
      base_q    <= '0;
      len_q     <= '0;
      circ_q    <= 1'b0;
      offset_q  <= '0;
      wcnt_q    <= '0;
      last_mb_q <= 1'b1;
      done_q    <= 1'b0;
      wrap_q    <= 1'b0;
      we_q      <= 1'b0;
      wdsel_q   <= 1'b0;
      w_mode_q  <= '0;
      w_addr_q  <= '0;
      w_data_q  <= '0;
      mb_data_q <= '0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      len_q     <= len_d;
      circ_q    <= circ_d;
      offset_q  <= offset_d;
      wcnt_q    <= wcnt_d;
      last_mb_q <= last_mb_d;
      done_q    <= done_d;
      wrap_q    <= wrap_d;
      we_q      <= we_d;
      wdsel_q   <= wdsel_d;
      w_mode_q  <= w_mode_d;
      w_addr_q  <= w_addr_d;
      w_data_q  <= w_data_d;
      mb_data_q <= mb_data_d;
    end
  end

endmodule

// File: tb/tb_tpram_wr_arb.sv
// Directed bench for tpram_wr_arb: reset, fabric writes, single/circular streams,
// contention, STOP during a handshake and power-down blocking.
module tb_tpram_wr_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fab_req;
  logic [11:0] fab_addr;
  logic [1:0]  fab_mode;
  logic [31:0] fab_data;
  logic        fab_gnt;
  logic        mb_valid;
  logic [31:0] mb_data;
  logic        mb_rdy;
  logic [11:0] cfg_base;
  logic [9:0]  cfg_len;
  logic        cfg_circ, cfg_start, cfg_stop, powerdn;
  logic        mb_busy, mb_done, mb_wrap;
  logic [10:0] mb_wcnt;
  logic        we, wdsel;
  logic [1:0]  w_mode;
  logic [11:0] w_addr;
  logic [31:0] w_data, m_wdata;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  tpram_wr_arb dut (
    .EFPGA_TPRAM_W_CLK (clk),
    .EFPGA_TPRAM_W_RSTN(rst_n),
    .FAB_REQ           (fab_req),
    .FAB_ADDR          (fab_addr),
    .FAB_MODE          (fab_mode),
    .FAB_DATA          (fab_data),
    .FAB_GNT           (fab_gnt),
    .MATHB_VALID       (mb_valid),
    .MATHB_DATA        (mb_data),
    .MATHB_RDY         (mb_rdy),
    .CFG_MB_BASE       (cfg_base),
    .CFG_MB_LEN        (cfg_len),
    .CFG_MB_CIRC       (cfg_circ),
    .CFG_MB_START      (cfg_start),
    .CFG_MB_STOP       (cfg_stop),
    .TPRAM_POWERDN     (powerdn),
    .MB_BUSY           (mb_busy),
    .MB_DONE           (mb_done),
    .MB_WRAP           (mb_wrap),
    .MB_WCNT           (mb_wcnt),
    .EFPGA_TPRAM_WE    (we),
    .EFPGA_TPRAM_WDSEL (wdsel),
    .EFPGA_TPRAM_W_MODE(w_mode),
    .EFPGA_TPRAM_W_ADDR(w_addr),
    .EFPGA_TPRAM_W_DATA(w_data),
    .MATHB_TPRAM_W_DATA(m_wdata)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, got);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled 1 unit later.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  logic [11:0] circ_addr [6] = '{12'hFF8, 12'hFFC, 12'h000, 12'h004, 12'hFF8, 12'hFFC};

  initial begin
    rst_n = 1'b0; fab_req = 1'b1; fab_addr = 12'h040; fab_mode = 2'b00; fab_data = 32'h11223344;
    mb_valid = 1'b0; mb_data = '0; cfg_base = '0; cfg_len = '0; cfg_circ = 1'b0;
    cfg_start = 1'b0; cfg_stop = 1'b0; powerdn = 1'b0;

    // Reset with a pending fabric request
    repeat (3) tick;
    chk("rst_we", we, 0);
    chk("rst_gnt", fab_gnt, 0);
    chk("rst_addr", w_addr, 0);
    chk("rst_busy", mb_busy, 0);
    chk("rst_wcnt", mb_wcnt, 0);
    rst_n = 1'b1; #1;
    chk("rst_first_gnt", fab_gnt, 1);
    tick;
    fab_req = 1'b0;
    chk("rst_first_we", we, 1);
    chk("rst_first_addr", w_addr, 12'h040);
    chk("rst_first_data", w_data, 32'h11223344);
    chk("rst_first_wdsel", wdsel, 0);
    tick;
    chk("idle_we", we, 0);
    chk("idle_addr_hold", w_addr, 12'h040);

    // Byte write
    fab_req = 1'b1; fab_addr = 12'h013; fab_mode = 2'b10; fab_data = 32'h000000A5; #1;
    chk("byte_gnt", fab_gnt, 1);
    tick;
    fab_req = 1'b0;
    chk("byte_we", we, 1);
    chk("byte_addr", w_addr, 12'h013);
    chk("byte_mode", w_mode, 2'b10);
    chk("byte_data", w_data, 32'h000000A5);
    chk("byte_wdsel", wdsel, 0);

    // Single pass, 4 words at 0x100
    cfg_base = 12'h100; cfg_len = 10'd3; cfg_circ = 1'b0; cfg_start = 1'b1;
    tick;
    cfg_start = 1'b0;
    chk("sp_busy", mb_busy, 1);
    chk("sp_wcnt0", mb_wcnt, 0);
    mb_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      mb_data = 32'h1000 + k; #1;
      chk($sformatf("sp_rdy%0d", k), mb_rdy, 1);
      tick;
      chk($sformatf("sp_we%0d", k), we, 1);
      chk($sformatf("sp_addr%0d", k), w_addr, 12'h100 + 12'(4 * k));
      chk($sformatf("sp_wdsel%0d", k), wdsel, 1);
      chk($sformatf("sp_mode%0d", k), w_mode, 0);
      chk($sformatf("sp_mdata%0d", k), m_wdata, 32'h1000 + k);
      chk($sformatf("sp_done%0d", k), mb_done, (k == 3) ? 1 : 0);
    end
    chk("sp_busy_end", mb_busy, 0);
    chk("sp_wcnt_end", mb_wcnt, 4);
    chk("sp_rdy_idle", mb_rdy, 0);
    tick;
    mb_valid = 1'b0;
    chk("sp_we_off", we, 0);
    chk("sp_done_pulse", mb_done, 0);

    // Circular window wrapping across the top of the address space
    cfg_base = 12'hFF8; cfg_len = 10'd3; cfg_circ = 1'b1; cfg_start = 1'b1;
    tick;
    cfg_start = 1'b0;
    mb_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      mb_data = 32'h2000 + k;
      tick;
      chk($sformatf("circ_addr%0d", k), w_addr, circ_addr[k]);
      chk($sformatf("circ_wrap%0d", k), mb_wrap, (k == 3) ? 1 : 0);
      chk($sformatf("circ_busy%0d", k), mb_busy, 1);
    end
    mb_valid = 1'b0;
    chk("circ_wcnt", mb_wcnt, 6);
    cfg_stop = 1'b1;
    tick;
    cfg_stop = 1'b0;
    chk("circ_stop_busy", mb_busy, 0);
    chk("circ_stop_done", mb_done, 0);

    // Contention: last grant was math, so fabric wins the first tie
    cfg_base = 12'h200; cfg_len = 10'd1023; cfg_circ = 1'b0; cfg_start = 1'b1;
    tick;
    cfg_start = 1'b0;
    fab_req = 1'b1; fab_addr = 12'h300; fab_mode = 2'b00; fab_data = 32'hF0F0F0F0;
    mb_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      mb_data = 32'h3000 + i; #1;
      chk($sformatf("ct_fgnt%0d", i), fab_gnt, (i % 2 == 0) ? 1 : 0);
      chk($sformatf("ct_mrdy%0d", i), mb_rdy, (i % 2 == 1) ? 1 : 0);
      tick;
      chk($sformatf("ct_we%0d", i), we, 1);
      chk($sformatf("ct_wdsel%0d", i), wdsel, i % 2);
      chk($sformatf("ct_addr%0d", i), w_addr, (i % 2 == 0) ? 12'h300 : 12'h200 + 12'(4 * (i / 2)));
    end
    fab_req = 1'b0; mb_valid = 1'b0;
    tick;
    chk("ct_we_off", we, 0);

    // STOP in the same cycle as a math handshake: word lands, no DONE
    mb_valid = 1'b1; mb_data = 32'hDEADBEEF; cfg_stop = 1'b1; #1;
    chk("stop_rdy", mb_rdy, 1);
    tick;
    cfg_stop = 1'b0; mb_valid = 1'b0;
    chk("stop_we", we, 1);
    chk("stop_addr", w_addr, 12'h210);
    chk("stop_mdata", m_wdata, 32'hDEADBEEF);
    chk("stop_busy", mb_busy, 0);
    chk("stop_done", mb_done, 0);
    chk("stop_wcnt", mb_wcnt, 5);

    // Power-down blocks both requesters; stream state holds
    cfg_base = 12'h000; cfg_len = 10'd3; cfg_circ = 1'b0; cfg_start = 1'b1;
    tick;
    cfg_start = 1'b0;
    powerdn = 1'b1; fab_req = 1'b1; mb_valid = 1'b1; mb_data = 32'h4444; #1;
    chk("pd_fgnt", fab_gnt, 0);
    chk("pd_mrdy", mb_rdy, 0);
    tick;
    chk("pd_we0", we, 0);
    chk("pd_busy", mb_busy, 1);
    tick;
    chk("pd_we1", we, 0);
    powerdn = 1'b0; fab_req = 1'b0; #1;
    chk("pd_release_rdy", mb_rdy, 1);
    tick;
    mb_valid = 1'b0;
    chk("pd_release_addr", w_addr, 12'h000);
    chk("pd_release_wcnt", mb_wcnt, 1);
    cfg_stop = 1'b1;
    tick;
    cfg_stop = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
